// File: rtl/key_digit_display.sv
// key_digit_display: keeps the last NDIGITS decimal digits typed on a PS/2 keyboard
// and scans them onto a multiplexed 7-segment display.
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_scan_valid, i_scancode  1-cycle strobe with a released-key set-2 make code
//   o_seg                     shared segments, [6:0]=abcdefg, [7]=dp, active-high
//   o_an                      one-hot digit enable, bit 0 = rightmost digit
//   o_count                   number of stored digits
//   o_overflow                sticky: a digit was pushed out on the left
module key_digit_display #(
  parameter int NDIGITS     = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_scan_valid,
  input  logic [7:0]         i_scancode,
  output logic [7:0]         o_seg,
  output logic [NDIGITS-1:0] o_an,
  output logic [3:0]         o_count,
  output logic               o_overflow
);
  localparam int DW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NDIGITS);
  logic [3:0]    r_slot [NDIGITS];
  logic [DW-1:0] r_div;
  logic [IW-1:0] r_idx;
  logic [3:0]    w_dig;
  logic          w_wrap;
  function automatic logic [7:0] pattern(input logic [3:0] d);
    case (d)
      4'd0:    pattern = 8'h7E;
      4'd1:    pattern = 8'h30;
      4'd2:    pattern = 8'h6D;
      4'd3:    pattern = 8'h79;
      4'd4:    pattern = 8'h33;
      4'd5:    pattern = 8'h5B;
      4'd6:    pattern = 8'h5F;
      4'd7:    pattern = 8'h72;
      4'd8:    pattern = 8'h7F;
      4'd9:    pattern = 8'h7B;
      default: pattern = 8'h00;
    endcase
  endfunction
  // 4'hF doubles as "not a digit key" and as the blank slot code
  always_comb begin
    w_dig = 4'hF;
    case (i_scancode)
      8'h45:   w_dig = 4'd0;
      8'h16:   w_dig = 4'd1;
      8'h1E:   w_dig = 4'd2;
      8'h26:   w_dig = 4'd3;
      8'h25:   w_dig = 4'd4;
      8'h2E:   w_dig = 4'd5;
      8'h36:   w_dig = 4'd6;
      8'h3D:   w_dig = 4'd7;
      8'h3E:   w_dig = 4'd8;
      8'h46:   w_dig = 4'd9;
      default: w_dig = 4'hF;
    endcase
  end
  assign w_wrap = r_div == DW'(REFRESH_DIV - 1);
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int k = 0; k < NDIGITS; k++) r_slot[k] <= 4'hF;
      o_count    <= '0;
      o_overflow <= 1'b0;
      r_div      <= '0;
      r_idx      <= '0;
      o_an       <= NDIGITS'(1);
      o_seg      <= 8'h00;
    end else begin
      r_div <= w_wrap ? '0 : r_div + 1'b1;
      if (w_wrap) r_idx <= (r_idx == IW'(NDIGITS - 1)) ? '0 : r_idx + 1'b1;
      o_an  <= NDIGITS'(1) << r_idx;
      o_seg <= pattern(r_slot[r_idx]);
      if (i_scan_valid) begin
        if (w_dig != 4'hF) begin
          for (int k = NDIGITS - 1; k > 0; k--) r_slot[k] <= r_slot[k-1];
          r_slot[0] <= w_dig;
          if (o_count == 4'(NDIGITS)) o_overflow <= 1'b1;
          else o_count <= o_count + 1'b1;
        end else if (i_scancode == 8'h66) begin
          for (int k = 0; k < NDIGITS - 1; k++) r_slot[k] <= r_slot[k+1];
          r_slot[NDIGITS-1] <= 4'hF;
          if (o_count != 4'd0) o_count <= o_count - 1'b1;
        end else if (i_scancode == 8'h76) begin
          for (int k = 0; k < NDIGITS; k++) r_slot[k] <= 4'hF;
          o_count    <= '0;
          o_overflow <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_key_digit_display.sv
// tb_key_digit_display: directed self-checking bench for key_digit_display (NDIGITS=4, REFRESH_DIV=4).
module tb_key_digit_display;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic [7:0] seg;
  logic [3:0] an;
  logic [3:0] count;
  logic       overflow;
  int checks = 0;
  int fails = 0;
  key_digit_display #(.NDIGITS(4), .REFRESH_DIV(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_scan_valid(scan_valid), .i_scancode(scancode),
    .o_seg(seg), .o_an(an), .o_count(count), .o_overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic strobe(input logic [7:0] code);
    scan_valid = 1'b1;
    scancode = code;
    step();
    scan_valid = 1'b0;
    scancode = 8'h00;
  endtask
  task automatic wait_an(input logic [3:0] t);
    int n = 0;
    step();
    while (an !== t && n < 20) begin
      step();
      n++;
    end
    chk("wait_an", {4'h0, an}, {4'h0, t});
  endtask
  task automatic show(input string tag, input logic [3:0] t, input logic [7:0] exp);
    wait_an(t);
    chk(tag, seg, exp);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask
  initial begin
    // 1: reset and idle scan; the reset edge is edge 0
    do_reset();
    chk("rst_an", {4'h0, an}, 8'h01);
    chk("rst_seg", seg, 8'h00);
    chk("rst_count", {4'h0, count}, 8'h00);
    chk("rst_ovf", {7'h0, overflow}, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("idle_an", {4'h0, an}, 8'(1 << (((k - 1) / 4) % 4)));
      chk("idle_seg", seg, 8'h00);
    end
    // 2: type 1,2,3
    strobe(8'h16);
    strobe(8'h1E);
    strobe(8'h26);
    chk("t2_count", {4'h0, count}, 8'h03);
    chk("t2_ovf", {7'h0, overflow}, 8'h00);
    show("t2_d0", 4'h1, 8'h79);
    show("t2_d1", 4'h2, 8'h6D);
    show("t2_d2", 4'h4, 8'h30);
    show("t2_d3", 4'h8, 8'h00);
    // 3: overflow, then backspace
    strobe(8'h25);
    strobe(8'h2E);
    chk("t3_count", {4'h0, count}, 8'h04);
    chk("t3_ovf", {7'h0, overflow}, 8'h01);
    show("t3_d0", 4'h1, 8'h5B);
    show("t3_d1", 4'h2, 8'h33);
    show("t3_d2", 4'h4, 8'h79);
    show("t3_d3", 4'h8, 8'h6D);
    strobe(8'h66);
    chk("t3_bs_count", {4'h0, count}, 8'h03);
    chk("t3_bs_ovf", {7'h0, overflow}, 8'h01);
    show("t3_bs_d0", 4'h1, 8'h33);
    show("t3_bs_d2", 4'h4, 8'h6D);
    show("t3_bs_d3", 4'h8, 8'h00);
    // 4: Esc clears, backspace on empty, ignored codes
    strobe(8'h76);
    chk("t4_esc_count", {4'h0, count}, 8'h00);
    chk("t4_esc_ovf", {7'h0, overflow}, 8'h00);
    show("t4_esc_d0", 4'h1, 8'h00);
    show("t4_esc_d2", 4'h4, 8'h00);
    strobe(8'h66);
    chk("t4_bs0_count", {4'h0, count}, 8'h00);
    strobe(8'h3D);
    strobe(8'hF0);
    strobe(8'hE0);
    strobe(8'h1C);
    chk("t4_ign_count", {4'h0, count}, 8'h01);
    show("t4_ign_d0", 4'h1, 8'h72);
    show("t4_ign_d1", 4'h2, 8'h00);
    strobe(8'h76);
    chk("t4_esc2_count", {4'h0, count}, 8'h00);
    show("t4_esc2_d0", 4'h1, 8'h00);
    // 5: reset mid-scan with a simultaneous key
    strobe(8'h16);
    strobe(8'h1E);
    strobe(8'h26);
    chk("t5_pre_count", {4'h0, count}, 8'h03);
    wait_an(4'h4);
    reset = 1'b1;
    scan_valid = 1'b1;
    scancode = 8'h45;
    step();
    reset = 1'b0;
    scan_valid = 1'b0;
    scancode = 8'h00;
    chk("t5_an", {4'h0, an}, 8'h01);
    chk("t5_seg", seg, 8'h00);
    chk("t5_count", {4'h0, count}, 8'h00);
    chk("t5_ovf", {7'h0, overflow}, 8'h00);
    step();
    chk("t5_key_ignored", {4'h0, count}, 8'h00);
    // 6: key on the edge where the scan wraps from idx 3 to idx 0 (edge 16 after reset)
    do_reset();
    repeat (15) step();
    scan_valid = 1'b1;
    scancode = 8'h46;
    step();
    scan_valid = 1'b0;
    scancode = 8'h00;
    chk("t6_wrap_an", {4'h0, an}, 8'h08);
    chk("t6_wrap_seg", seg, 8'h00);
    step();
    chk("t6_an", {4'h0, an}, 8'h01);
    chk("t6_seg", seg, 8'h7B);
    chk("t6_count", {4'h0, count}, 8'h01);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
